// File: rtl/unidade_controle_exp2.sv
// Moore control unit for the counter/comparator datapath: start, per-entry compare,
// then success, mismatch error or inactivity timeout.
module unidade_controle_exp2 #(
    parameter int TIMEOUT = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       carga,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim,
    output logic       zera,
    output logic       carrega,
    output logic       conta,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL = 4'b0000,
        PREPARA = 4'b0001,
        CARREGA = 4'b0010,
        ESPERA  = 4'b0011,
        COMPARA = 4'b0100,
        PROXIMO = 4'b0101,
        ACERTO  = 4'b1010,
        ERRO    = 4'b1110,
        TEMPO   = 4'b1111
    } estado_t;

    estado_t     estado, proximo;
    logic        jogada_d;
    logic [15:0] cnt_tempo;
    logic        jogada_borda;
    logic        expirou;

    assign jogada_borda = jogada & ~jogada_d;
    assign expirou      = (cnt_tempo == 16'(TIMEOUT - 1));

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL, ACERTO, ERRO, TEMPO: begin
                if (iniciar)
                    proximo = carga ? CARREGA : PREPARA;
                else
                    proximo = estado;
            end
            PREPARA: proximo = ESPERA;
            CARREGA: proximo = ESPERA;
            // entry edge takes priority over a coincident timeout expiry
            ESPERA: begin
                if (jogada_borda)
                    proximo = COMPARA;
                else if (expirou)
                    proximo = TEMPO;
                else
                    proximo = ESPERA;
            end
            COMPARA: begin
                if (!igual)
                    proximo = ERRO;
                else if (fim)
                    proximo = ACERTO;
                else
                    proximo = PROXIMO;
            end
            PROXIMO: proximo = ESPERA;
            default: proximo = INICIAL;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= INICIAL;
            jogada_d  <= 1'b0;
            cnt_tempo <= 16'd0;
            zera      <= 1'b0;
            carrega   <= 1'b0;
            conta     <= 1'b0;
            pronto    <= 1'b0;
            acertou   <= 1'b0;
            errou     <= 1'b0;
            timeout   <= 1'b0;
            db_estado <= 4'b0000;
        end else begin
            estado    <= proximo;
            jogada_d  <= jogada;
            cnt_tempo <= (estado == ESPERA) ? cnt_tempo + 16'd1 : 16'd0;
            zera      <= (proximo == PREPARA);
            carrega   <= (proximo == CARREGA);
            conta     <= (proximo == PROXIMO);
            pronto    <= (proximo == ACERTO) || (proximo == ERRO) || (proximo == TEMPO);
            acertou   <= (proximo == ACERTO);
            errou     <= (proximo == ERRO) || (proximo == TEMPO);
            timeout   <= (proximo == TEMPO);
            db_estado <= proximo;
        end
    end

endmodule

// File: doc/unidade_controle_exp2.md
# unidade_controle_exp2

Moore control unit that drives the counter/comparator datapath (counter with synchronous clear and load, 4-bit magnitude comparator against `chaves`, hex display). It issues `zera`, `carrega` and `conta` to the datapath and consumes its `igual` and `fim` flags. The sequence it runs: start, then check each user entry (`jogada`) against the current count. It ends in success after the last position, or in error on a mismatch or an inactivity timeout.

## Interface
- `TIMEOUT`, default 5000: clock cycles allowed in ESPERA without a `jogada` edge before aborting; legal range 2..65535.
- `clock  in  1`: single clock, all state updates on the rising edge.
- `reset  in  1`: synchronous, active-high. Forces INICIAL and clears all internal registers.
- `iniciar  in  1`: start request, level-sampled in INICIAL, ACERTO, ERRO and TEMPO.
- `carga  in  1`: start mode sampled with `iniciar`. 0 means clear the counter; 1 means load `chaves` into the counter.
- `jogada  in  1`: user entry strobe, rising-edge detected internally.
- `igual  in  1`: datapath comparator equal flag.
- `fim  in  1`: datapath counter terminal count (rco).
- `zera  out  1`: datapath synchronous clear, active-high.
- `carrega  out  1`: datapath synchronous load, active-high.
- `conta  out  1`: datapath count enable.
- `pronto  out  1`: sequence finished (any outcome).
- `acertou  out  1`: finished with success.
- `errou  out  1`: finished with failure (mismatch or timeout).
- `timeout  out  1`: failure cause was inactivity.
- `db_estado  out  4`: current state code, for debug display.

## Operation
- State codes:
  - INICIAL 0000
  - PREPARA 0001
  - CARREGA 0010
  - ESPERA 0011
  - COMPARA 0100
  - PROXIMO 0101
  - ACERTO 1010
  - ERRO 1110
  - TEMPO 1111
- Unused codes return to INICIAL.
- Outputs are pure Moore, decoded from the state register:
  - `zera` only in PREPARA.
  - `carrega` only in CARREGA.
  - `conta` only in PROXIMO.
  - `pronto` in ACERTO, ERRO and TEMPO.
  - `acertou` in ACERTO.
  - `errou` in ERRO and TEMPO.
  - `timeout` in TEMPO.
- Transitions:
  - INICIAL: `iniciar` goes to PREPARA if `carga`=0, or to CARREGA if `carga`=1. Otherwise it holds.
  - PREPARA and CARREGA: go to ESPERA unconditionally, one cycle each.
  - ESPERA: a `jogada` edge goes to COMPARA. Timeout expiry goes to TEMPO. Otherwise it holds.
  - COMPARA:
    - `igual`=0 goes to ERRO.
    - `igual`=1 and `fim`=1 goes to ACERTO.
    - `igual`=1 and `fim`=0 goes to PROXIMO.
  - PROXIMO: goes to ESPERA.
  - ACERTO, ERRO and TEMPO: hold. `iniciar` restarts exactly as from INICIAL, honouring `carga`.
- Edge detector:
  - `jogada_d` register, reset value 0.
  - Edge = `jogada` & ~`jogada_d`; `jogada_d` updates every cycle in every state.
  - Edges outside ESPERA are discarded.
  - A `jogada` level held high when ESPERA is entered produces no edge.
- Timeout counter:
  - 16-bit, cleared (set to 0) in every state other than ESPERA.
  - Increments each cycle spent in ESPERA.
  - Expiry when count = `TIMEOUT`-1 while in ESPERA, i.e. the `TIMEOUT`-th consecutive ESPERA cycle.
  - It never wraps, because it is cleared on exit from ESPERA.
- Simultaneous events:
  - A `jogada` edge and timeout expiry in the same cycle: the `jogada` edge wins (go to COMPARA).
  - `reset` dominates everything.
  - `iniciar` in PREPARA, CARREGA, ESPERA, COMPARA or PROXIMO is ignored.
- `igual` and `fim` are trusted only in COMPARA. `chaves` must be stable from the `jogada` edge through COMPARA; the bench guarantees this.

## Timing
- After a `reset` edge:
  - State is INICIAL.
  - All outputs are 0 and `db_estado` is 0000.
  - `jogada_d` and the timeout counter are 0.
- `iniciar` sampled high at edge N: `zera` (or `carrega`) is high during cycle N..N+1. The datapath clears or loads at edge N+1, and ESPERA begins at edge N+1.
- A `jogada` rise sampled at edge M in ESPERA: COMPARA during M..M+1.
  - The outcome state is registered at edge M+1.
  - `acertou`/`errou` are therefore visible 2 edges after the `jogada` rise is sampled.
- `conta` lasts exactly one cycle per accepted entry. The datapath increments at the edge ending PROXIMO, and ESPERA resumes at that same edge.
- A `reset` asserted mid-sequence takes effect at the next edge, with no further `zera`/`conta` pulses after it.

## Test plan
- Reset check: `reset`=1 for 2 cycles with `jogada`=1 held, then released → `db_estado`=0000, all outputs 0, no COMPARA entry.
- Full success run, `carga`=0: `iniciar` pulse, then 16 `jogada` edges with `igual`=1 and `fim`=1 on the 16th.
  - Exactly one `zera` pulse and 15 `conta` pulses.
  - `pronto`=`acertou`=1, `db_estado`=1010.
- Mismatch: `iniciar`, 3 correct entries, 4th with `igual`=0 → ERRO, `errou`=1, `timeout`=0, exactly 3 `conta` pulses; `iniciar` with `carga`=1 then gives one `carrega` pulse and ESPERA.
- Timeout with `TIMEOUT`=8: enter ESPERA and hold `jogada`=0 → TEMPO on the 8th ESPERA cycle, with `errou`=`timeout`=1.
  - `jogada` edge on the 8th cycle instead → COMPARA.
  - An entry at cycle 7 → counter restarts after PROXIMO.
- Edge filtering: hold `jogada`=1 across the `iniciar` sequence into ESPERA → no COMPARA until `jogada` falls and rises again; `iniciar` pulses in ESPERA are ignored.
- Reset mid-sequence: `reset` in PROXIMO → INICIAL at the next edge, `conta` deasserted, timeout counter 0.
